// File: rtl/job_io_ctrl.sv
// Job I/O controller: serial job/daisy shift-in from an asynchronous data_clk,
// result FIFO from the hashing pool and serial result shift-out.
//
// Result input handshake: a word on result_in is taken on any clk edge where
// result_valid=1, result_ready=1 and load=0. With result_valid=1 and the FIFO
// full, the word is dropped and overflow is set. In load mode result_valid is
// ignored completely.
module job_io_ctrl #(
    parameter int JOB_WIDTH    = 360,
    parameter int DAISY_WIDTH  = 8,
    parameter int RESULT_WIDTH = 32,
    parameter int RESULT_DEPTH = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          data_clk,
    input  logic                          data_in,
    input  logic                          daisy_sel,
    input  logic                          daisy_in,
    output logic                          daisy_out,
    output logic [JOB_WIDTH-1:0]          job_params,
    output logic [DAISY_WIDTH-1:0]        daisy_params,
    output logic                          job_start,
    output logic                          job_error,
    input  logic [RESULT_WIDTH-1:0]       result_in,
    input  logic                          result_valid,
    output logic                          result_ready,
    output logic                          data_out,
    output logic                          data_oe,
    output logic [$clog2(RESULT_DEPTH):0] result_count,
    output logic                          overflow
);
    localparam int AW = $clog2(RESULT_DEPTH);
    localparam int CW = $clog2(JOB_WIDTH + 2);
    localparam int BW = $clog2(RESULT_WIDTH + 1);
    localparam logic [CW-1:0] JOB_FULL  = CW'(JOB_WIDTH);
    localparam logic [CW-1:0] JOB_SAT   = CW'(JOB_WIDTH + 1);
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(RESULT_DEPTH);
    localparam logic [AW:0]   ONE_ENTRY = (AW+1)'(1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(RESULT_WIDTH - 1);

    logic [SYNC_STAGES-1:0]  r_dclk_sync;
    logic [SYNC_STAGES-1:0]  r_din_sync;
    logic [SYNC_STAGES-1:0]  r_dzin_sync;
    logic                    r_dclk_prev;
    logic                    r_load_prev;

    logic [JOB_WIDTH-1:0]    r_job;
    logic [DAISY_WIDTH-1:0]  r_daisy;
    logic [CW-1:0]           r_job_cnt;
    logic                    r_job_start;
    logic                    r_job_error;

    logic [RESULT_WIDTH-1:0] r_mem [RESULT_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_count;
    logic [RESULT_WIDTH-1:0] r_osr;
    logic [BW-1:0]           r_bit_cnt;
    logic                    r_overflow;

    logic w_dclk_edge, w_din, w_dzin, w_load_rise, w_load_fall;
    logic w_shift_daisy, w_shift_job, w_full, w_empty;
    logic w_push, w_drop, w_shift_out, w_pop;
    logic [RESULT_WIDTH-1:0] w_head_next;

    assign w_dclk_edge   = r_dclk_sync[SYNC_STAGES-1] & ~r_dclk_prev;
    assign w_din         = r_din_sync[SYNC_STAGES-1];
    assign w_dzin        = r_dzin_sync[SYNC_STAGES-1];
    assign w_load_rise   = load & ~r_load_prev;
    assign w_load_fall   = ~load & r_load_prev;
    assign w_shift_daisy = w_dclk_edge & load & daisy_sel;
    assign w_shift_job   = w_dclk_edge & load & ~daisy_sel;
    assign w_full        = (r_count == FIFO_FULL);
    assign w_empty       = (r_count == '0);
    assign w_push        = result_valid & ~load & ~w_full;
    assign w_drop        = result_valid & ~load & w_full;
    assign w_shift_out   = w_dclk_edge & ~load & ~w_empty;
    assign w_pop         = w_shift_out & (r_bit_cnt == LAST_BIT);
    // After a pop the new head is the next stored word, or the word being
    // pushed this very cycle when the popped word was the only one.
    assign w_head_next   = (r_count > ONE_ENTRY) ? r_mem[r_rd_ptr + AW'(1)] : result_in;

    // Synchronize the external serial inputs and keep last-cycle copies for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dclk_sync <= '0;
            r_din_sync  <= '0;
            r_dzin_sync <= '0;
            r_dclk_prev <= 1'b0;
            r_load_prev <= 1'b0;
        end else begin
            r_dclk_sync <= {r_dclk_sync[SYNC_STAGES-2:0], data_clk};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], data_in};
            r_dzin_sync <= {r_dzin_sync[SYNC_STAGES-2:0], daisy_in};
            r_dclk_prev <= r_dclk_sync[SYNC_STAGES-1];
            r_load_prev <= load;
        end
    end

    // Job/daisy shift-in, job bit counting and commit/error on leaving load mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_job       <= '0;
            r_daisy     <= '0;
            r_job_cnt   <= '0;
            r_job_start <= 1'b0;
            r_job_error <= 1'b0;
        end else begin
            r_job_start <= w_load_fall && (r_job_cnt == JOB_FULL);
            if (w_shift_daisy) r_daisy <= {w_dzin, r_daisy[DAISY_WIDTH-1:1]};
            if (w_shift_job)   r_job   <= {w_din, r_job[JOB_WIDTH-1:1]};
            if (w_load_rise) begin
                r_job_cnt   <= w_shift_job ? CW'(1) : '0;
                r_job_error <= 1'b0;
            end else begin
                if (w_shift_job && (r_job_cnt != JOB_SAT)) r_job_cnt <= r_job_cnt + CW'(1);
                if (w_load_fall && (r_job_cnt != JOB_FULL)) r_job_error <= 1'b1;
            end
        end
    end

    // Result FIFO, output shift register and overflow tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RESULT_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_osr      <= '0;
            r_bit_cnt  <= '0;
            r_overflow <= 1'b0;
        end else if (w_load_rise) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_osr      <= '0;
            r_bit_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= result_in;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + ONE_ENTRY;
            else if (w_pop && !w_push) r_count <= r_count - ONE_ENTRY;
            if (w_drop) r_overflow <= 1'b1;

            if (w_pop) begin
                r_bit_cnt <= '0;
                if ((r_count > ONE_ENTRY) || w_push) r_osr <= w_head_next;
            end else if (w_shift_out) begin
                r_osr     <= r_osr >> 1;
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end else if (w_push && w_empty) begin
                r_osr <= result_in;
            end
        end
    end

    assign daisy_out    = r_daisy[0];
    assign job_params   = r_job;
    assign daisy_params = r_daisy;
    assign job_start    = r_job_start;
    assign job_error    = r_job_error;
    assign result_ready = ~w_full;
    assign result_count = r_count;
    assign overflow     = r_overflow;
    assign data_oe      = ~load & ~w_empty;
    assign data_out     = data_oe & r_osr[0];

endmodule

// File: tb/tb_job_io_ctrl.sv
// Testbench for job_io_ctrl: directed sequence with random data, checked
// against a behavioural model (bit-stream job/daisy images, result word queue).
module tb_job_io_ctrl;
  localparam int JW   = 360;
  localparam int DW   = 8;
  localparam int RW   = 32;
  localparam int RD   = 4;
  localparam int SS   = 2;
  localparam int CNTW = $clog2(RD) + 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic            load, data_clk, data_in, daisy_sel, daisy_in;
  logic            daisy_out, job_start, job_error;
  logic [JW-1:0]   job_params;
  logic [DW-1:0]   daisy_params;
  logic [RW-1:0]   result_in;
  logic            result_valid, result_ready, data_out, data_oe, overflow;
  logic [CNTW-1:0] result_count;

  job_io_ctrl #(
    .JOB_WIDTH(JW), .DAISY_WIDTH(DW), .RESULT_WIDTH(RW),
    .RESULT_DEPTH(RD), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .data_clk(data_clk),
    .data_in(data_in), .daisy_sel(daisy_sel), .daisy_in(daisy_in),
    .daisy_out(daisy_out), .job_params(job_params), .daisy_params(daisy_params),
    .job_start(job_start), .job_error(job_error), .result_in(result_in),
    .result_valid(result_valid), .result_ready(result_ready),
    .data_out(data_out), .data_oe(data_oe), .result_count(result_count),
    .overflow(overflow)
  );

  // scoreboard / reference model
  int            n_checks = 0;
  int            n_err = 0;
  logic [RW-1:0] exp_q[$];
  logic          exp_ovf;
  logic [JW-1:0] job_exp;
  logic [DW-1:0] daisy_exp;

  task automatic chk(input string tag, input logic [JW-1:0] obs, input logic [JW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks (called right after a falling clk edge)
  task automatic dclk_bit(input logic d, input logic dz, output logic q);
    q        = data_out;
    data_in  = d;
    daisy_in = dz;
    data_clk = 1'b1;
    repeat (SS + 2) @(negedge clk);
    data_clk = 1'b0;
    repeat (SS + 2) @(negedge clk);
  endtask

  task automatic push_word(input logic [RW-1:0] w);
    result_in    = w;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    if (!load) begin
      if (exp_q.size() < RD) exp_q.push_back(w);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic read_word(output logic [RW-1:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < RW; i++) begin
      dclk_bit(1'b0, 1'b0, b);
      w[i] = b;
    end
  endtask

  task automatic count_starts(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (job_start === 1'b1) n++;
    end
  endtask

  initial begin
    logic          q, b;
    logic [RW-1:0] w, acc, wa, wb;
    logic [DW-1:0] dv;
    logic [JW-1:0] pattern;
    int            n;

    reset = 1'b1; load = 1'b0; data_clk = 1'b0; data_in = 1'b0;
    daisy_sel = 1'b0; daisy_in = 1'b0; result_in = '0; result_valid = 1'b0;
    exp_ovf = 1'b0; job_exp = '0; daisy_exp = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_data_oe", JW'(data_oe), JW'(1'b0));
    chk("rst_data_out", JW'(data_out), JW'(1'b0));
    chk("rst_ready", JW'(result_ready), JW'(1'b1));
    chk("rst_count", JW'(result_count), JW'(0));
    chk("rst_job_start", JW'(job_start), JW'(1'b0));
    chk("rst_job_error", JW'(job_error), JW'(1'b0));
    chk("rst_overflow", JW'(overflow), JW'(1'b0));
    chk("rst_job_params", job_params, '0);
    chk("rst_daisy", JW'(daisy_params), JW'(0));
    reset = 1'b0;
    @(negedge clk);

    // daisy shift: 0xA5 then a random byte
    load = 1'b1; daisy_sel = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      dv = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      for (int i = 0; i < DW; i++) begin
        dclk_bit(1'($urandom_range(0, 1)), dv[i], q);
        daisy_exp = {dv[i], daisy_exp[DW-1:1]};
        chk("daisy_out", JW'(daisy_out), JW'(daisy_exp[0]));
      end
      chk("daisy_params", JW'(daisy_params), JW'(dv));
    end

    // full job: 360 random bits, top byte 0x03
    daisy_sel = 1'b0;
    for (int i = 0; i < JW; i++) pattern[i] = 1'($urandom_range(0, 1));
    pattern[JW-1 -: 8] = 8'h03;
    for (int i = 0; i < JW; i++) begin
      dclk_bit(pattern[i], 1'($urandom_range(0, 1)), q);
      job_exp = {pattern[i], job_exp[JW-1:1]};
    end
    chk("job_params_full", job_params, pattern);
    chk("daisy_kept", JW'(daisy_params), JW'(daisy_exp));
    load = 1'b0;
    count_starts(6, n);
    chk("job_start_once", JW'(n), JW'(1));
    chk("job_error_ok", JW'(job_error), JW'(1'b0));

    // short job: 359 bits
    load = 1'b1;
    @(negedge clk);
    for (int i = 0; i < JW - 1; i++) begin
      b = 1'($urandom_range(0, 1));
      dclk_bit(b, 1'b0, q);
      job_exp = {b, job_exp[JW-1:1]};
    end
    load = 1'b0;
    count_starts(6, n);
    chk("job_start_none", JW'(n), JW'(0));
    chk("job_error_short", JW'(job_error), JW'(1'b1));
    chk("job_params_short", job_params, job_exp);
    chk("daisy_retained", JW'(daisy_params), JW'(daisy_exp));

    // single result readout
    chk("oe_idle", JW'(data_oe), JW'(1'b0));
    push_word(32'h00000017);
    chk("oe_after_push", JW'(data_oe), JW'(1'b1));
    chk("count_one", JW'(result_count), JW'(exp_q.size()));
    chk("first_bit", JW'(data_out), JW'(1'b1));
    read_word(w);
    chk("readout_0x17", JW'(w), JW'(exp_q.pop_front()));
    chk("oe_drained", JW'(data_oe), JW'(1'b0));
    chk("count_drained", JW'(result_count), JW'(0));
    chk("data_out_idle", JW'(data_out), JW'(1'b0));

    // overflow: 5 random pushes into a 4-deep FIFO
    for (int i = 0; i < RD + 1; i++) push_word($urandom);
    chk("ready_full", JW'(result_ready), JW'(1'b0));
    chk("count_full", JW'(result_count), JW'(exp_q.size()));
    chk("overflow_set", JW'(overflow), JW'(exp_ovf));
    for (int i = 0; i < RD; i++) begin
      read_word(w);
      chk("readout_order", JW'(w), JW'(exp_q.pop_front()));
    end
    chk("oe_after_burst", JW'(data_oe), JW'(1'b0));

    // edges with an empty FIFO do nothing
    for (int i = 0; i < 3; i++) dclk_bit(1'b0, 1'b0, q);
    push_word($urandom);
    read_word(w);
    chk("readout_after_idle", JW'(w), JW'(exp_q.pop_front()));

    // push coinciding with the final-bit pop
    wa = $urandom;
    wb = $urandom;
    push_word(wa);
    acc = '0;
    for (int i = 0; i < RW - 1; i++) begin
      dclk_bit(1'b0, 1'b0, b);
      acc[i] = b;
    end
    acc[RW-1] = data_out;
    data_clk = 1'b1;
    repeat (SS) @(negedge clk);
    result_in = wb;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(wb);
    chk("coincide_word", JW'(acc), JW'(wa));
    chk("coincide_count", JW'(result_count), JW'(exp_q.size()));
    chk("coincide_oe", JW'(data_oe), JW'(1'b1));
    @(negedge clk);
    data_clk = 1'b0;
    repeat (SS + 2) @(negedge clk);
    read_word(w);
    chk("coincide_next", JW'(w), JW'(exp_q.pop_front()));
    chk("coincide_drained", JW'(result_count), JW'(0));

    // load=1: clears sticky flags, result_valid ignored
    load = 1'b1;
    @(negedge clk);
    chk("load_clears_error", JW'(job_error), JW'(1'b0));
    chk("load_clears_ovf", JW'(overflow), JW'(1'b0));
    exp_ovf = 1'b0;
    for (int i = 0; i < RD + 1; i++) push_word($urandom);
    chk("load_no_push", JW'(result_count), JW'(0));
    chk("load_no_ovf", JW'(overflow), JW'(exp_ovf));
    chk("load_ready", JW'(result_ready), JW'(1'b1));

    // reset in the middle of a readout
    load = 1'b0;
    @(negedge clk);
    push_word($urandom);
    for (int i = 0; i < 10; i++) dclk_bit(1'b0, 1'b0, q);
    data_clk = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_oe", JW'(data_oe), JW'(1'b0));
    chk("mid_rst_out", JW'(data_out), JW'(1'b0));
    chk("mid_rst_count", JW'(result_count), JW'(0));
    chk("mid_rst_ready", JW'(result_ready), JW'(1'b1));
    chk("mid_rst_error", JW'(job_error), JW'(1'b0));
    chk("mid_rst_job", job_params, '0);
    chk("mid_rst_daisy", JW'(daisy_params), JW'(0));
    data_clk = 1'b0;
    reset = 1'b0;
    count_starts(12, n);
    chk("post_rst_no_start", JW'(n), JW'(0));
    chk("post_rst_count", JW'(result_count), JW'(exp_q.size()));
    chk("post_rst_oe", JW'(data_oe), JW'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/job_io_ctrl.md
JOB_IO_CTRL -- requirements
Module: job_io_ctrl

Interface
REQ-001 Parameter JOB_WIDTH, default 360, job-parameter shift length in bits.
REQ-002 Parameter DAISY_WIDTH, default 8, per-device daisy configuration length in bits.
REQ-003 Parameter RESULT_WIDTH, default 32, width of one result word (nonce).
REQ-004 Parameter RESULT_DEPTH, default 4, result FIFO depth; power of two, at least 2.
REQ-005 Parameter SYNC_STAGES, default 2, synchronizer depth for data_clk, data_in, daisy_in; at least 2.
REQ-006 clk  input  1  single system clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 load  input  1  load mode: 1 = accept job/daisy shift-in, 0 = run/result shift-out.
REQ-009 data_clk  input  1  external serial clock, asynchronous to clk.
REQ-010 data_in  input  1  serial job data, LSB first.
REQ-011 daisy_sel  input  1  in load mode: 1 routes shifting to the daisy register, 0 to the job register.
REQ-012 daisy_in  input  1  serial daisy data, LSB first.
REQ-013 daisy_out  output  1  daisy register bit 0, feeding the next device in the chain.
REQ-014 job_params  output  JOB_WIDTH  job shift register contents.
REQ-015 daisy_params  output  DAISY_WIDTH  daisy shift register contents.
REQ-016 job_start  output  1  one-cycle pulse when a complete job is committed.
REQ-017 job_error  output  1  sticky flag: load was exited with a bit count not equal to JOB_WIDTH.
REQ-018 result_in  input  RESULT_WIDTH  result word from the hashing pool.
REQ-019 result_valid  input  1  result_in is valid this cycle.
REQ-020 result_ready  output  1  FIFO not full.
REQ-021 data_out  output  1  serial result data, LSB first.
REQ-022 data_oe  output  1  output enable for the external tristate on data_out.
REQ-023 result_count  output  log2(RESULT_DEPTH)+1  FIFO occupancy.
REQ-024 overflow  output  1  sticky flag: result offered while FIFO full.

Function
REQ-025 data_clk, data_in and daisy_in SHALL each pass through SYNC_STAGES flops; a data_clk edge is the synchronized data_clk at 1 with its previous registered value at 0.
REQ-026 The latency from a data_clk rise to the resulting register update SHALL be exactly SYNC_STAGES+1 clk cycles; data_clk high and low phases are each at least SYNC_STAGES+2 clk cycles.
REQ-027 On an edge with load=1 and daisy_sel=1: daisy register <= {data bit, daisy[DAISY_WIDTH-1:1]}, using synchronized daisy_in.
REQ-028 On an edge with load=1 and daisy_sel=0: job register <= {data bit, job[JOB_WIDTH-1:1]}, using synchronized data_in; the job bit counter increments and saturates at JOB_WIDTH+1.
REQ-029 A 0->1 transition of load SHALL clear the job bit counter, job_error, overflow and all FIFO contents in the following cycle; the job and daisy registers SHALL be retained.
REQ-030 On a 1->0 transition of load: if count == JOB_WIDTH, job_start pulses for one cycle on the next clk edge; otherwise job_error is set and job_start stays 0.
REQ-031 When result_valid=1 and result_ready=1, result_in SHALL be pushed; when result_valid=1 and the FIFO is full, the word is dropped and overflow is set.
REQ-032 A result_valid with load=1 SHALL be ignored; it neither pushes nor sets overflow.
REQ-033 data_oe = (load==0) and (result_count>0); data_out = bit 0 of the output shift register; data_out = 0 when data_oe = 0.
REQ-034 The output shift register SHALL load the FIFO head in the same cycle the FIFO goes non-empty, or immediately after a pop that leaves entries.
REQ-035 On each edge with load=0 and data_oe=1, the output shift register SHALL shift right by one and the bit counter increments; the edge that emits bit RESULT_WIDTH-1 pops the head and clears the counter.
REQ-036 A push and a pop in the same cycle SHALL both take effect, leaving result_count unchanged; FIFO pointers wrap modulo RESULT_DEPTH.
REQ-037 Edges with load=0 and an empty FIFO SHALL be ignored.

Reset
REQ-038 Asynchronous reset SHALL clear all registers: synchronizers, job/daisy registers, counters, FIFO, overflow, job_error, job_start; data_oe=0, data_out=0, result_ready=1, result_count=0.
REQ-039 Reset asserted mid-shift or mid-readout SHALL abort the operation; no partial job_start or pop follows deassertion.

Verification
REQ-040 load=1, daisy_sel=1, shift 8 bits of 0xA5 LSB first -> daisy_params=0xA5; daisy_out shows each outgoing bit.
REQ-041 load=1, daisy_sel=0, shift 360 bits (pattern ending 0x03), then load=0 -> job_params equals the pattern; exactly one job_start pulse; job_error=0.
REQ-042 Same as REQ-041 but with 359 bits -> job_error=1, no job_start.
REQ-043 load=0, push 0x00000017 -> data_oe=1; 32 data_clk edges -> serial capture 0x00000017; then data_oe=0 and result_count=0.
REQ-044 RESULT_DEPTH=4: push 5 words without readout -> result_ready=0 after 4, overflow=1, the 5th word is lost; readout returns words 1-4 in order.
REQ-045 Push coinciding with the final-bit pop -> result_count unchanged; the next word starts on the next edge; reset asserted mid-readout -> all outputs at reset values.
